// File: rtl/base_aarb_pkg.sv
// Shared definitions for the base_aarb packet-aware round-robin arbiter.
package base_aarb_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } lock_state_e;

  // Next round-robin index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/base_askid2.sv
// Two-entry ready/valid buffer; input ready comes straight from a flop so it
// never depends combinationally on downstream ready.
module base_askid2
  import base_aarb_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d
);

  logic [1:0]       count_q, count_d;
  logic             full_q, full_d;
  logic [width-1:0] slot0_q, slot0_d;
  logic [width-1:0] slot1_q, slot1_d;
  logic             push, pop;

  assign i_r  = ~full_q;
  assign o_v  = (count_q != 2'd0);
  assign o_d  = slot0_q;
  assign push = i_v & i_r;
  assign pop  = o_v & o_r;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) begin
      slot0_d = slot1_q;
      count_d = count_d - 2'd1;
    end
    // After the pop, count_d is exactly the slot the new beat lands in.
    if (push) begin
      if (count_d == 2'd0) slot0_d = i_d;
      else                 slot1_d = i_d;
      count_d = count_d + 2'd1;
    end
    full_d = (count_d == 2'(BUF_DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  // NOTE: the data slots are reset too because the outputs must read zero while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/base_aarb.sv
// Round-robin arbiter merging `ways` ready/valid streams, holding the grant for
// a whole packet, with a registered two-entry output buffer.
module base_aarb
  import base_aarb_pkg::*;
#(
  parameter int ways   = 4,
  parameter int width  = 8,
  parameter int swidth = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ways-1:0]       i_v,
  output logic [ways-1:0]       i_r,
  input  logic [ways*width-1:0] i_d,
  input  logic [ways-1:0]       i_e,
  input  logic                  o_r,
  output logic                  o_v,
  output logic [width-1:0]      o_d,
  output logic                  o_e,
  output logic [swidth-1:0]     o_s
);

  localparam int BW = width + 1 + swidth;

  lock_state_e       state_q, state_d;
  logic [swidth-1:0] owner_q, owner_d;
  logic [swidth-1:0] ptr_q, ptr_d;
  logic [swidth-1:0] gnt;
  logic              req, space, accept, gnt_e;
  logic [width-1:0]  gnt_d;
  logic [BW-1:0]     buf_out;

  always_comb begin : arb_comb
    int                idx;
    logic [swidth-1:0] cand;
    logic              found;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    gnt   = owner_q;
    if (state_q != ST_PKT) begin
      gnt = '0;
      for (int off = 0; off < ways; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= ways) idx = idx - ways;
        cand = swidth'(idx);
        if (!found && i_v[cand]) begin
          gnt   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Ready is forced low while reset is asserted, independent of the flops.
  always_comb begin
    req = (state_q == ST_PKT) | (|i_v);
    i_r = '0;
    for (int k = 0; k < ways; k++) begin
      i_r[k] = reset & space & req & (gnt == swidth'(k));
    end
    accept = |(i_v & i_r);
    gnt_d  = i_d[int'(gnt)*width +: width];
    gnt_e  = i_e[gnt];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (gnt_e) begin
            ptr_d = swidth'(rr_next(int'(gnt), ways));
          end else begin
            state_d = ST_PKT;
            owner_d = gnt;
          end
        end
      end
      ST_PKT: begin
        if (accept && gnt_e) begin
          state_d = ST_IDLE;
          ptr_d   = swidth'(rr_next(int'(owner_q), ways));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  base_askid2 #(
    .width(BW)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .i_v  (accept),
    .i_r  (space),
    .i_d  ({gnt_d, gnt_e, gnt}),
    .o_v  (o_v),
    .o_r  (o_r),
    .o_d  (buf_out)
  );

  assign {o_d, o_e, o_s} = buf_out;

endmodule

// File: tb/tb_base_aarb.sv
// Self-checking bench for base_aarb: per-input source queues, an expected-beat
// scoreboard, a backpressure vector table and hand-written corner sequences.
module tb_base_aarb;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic [1:0] s;
  } exp_t;

  typedef struct {
    logic       o_r;
    logic [3:0] ir;
    logic       ov;
    logic [7:0] od;
  } bp_vec_t;

  logic        clk, reset, o_r, o_v, o_e;
  logic [3:0]  i_v, i_r, i_e;
  logic [31:0] i_d;
  logic [7:0]  o_d;
  logic [1:0]  o_s;

  beat_t   src_q[4][$];
  exp_t    exp_q[$];
  bp_vec_t bp_tab[8];
  logic [3:0] mask, s_ir, s_fire;
  logic       s_ov;
  logic [7:0] s_od;
  int n_checks, n_fail;

  base_aarb #(.ways(4), .width(8), .swidth(2)) dut (
    .clk  (clk),
    .reset(reset),
    .i_v  (i_v),
    .i_r  (i_r),
    .i_d  (i_d),
    .i_e  (i_e),
    .o_r  (o_r),
    .o_v  (o_v),
    .o_d  (o_d),
    .o_e  (o_e),
    .o_s  (o_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic src_add(input int k, input logic [7:0] d, input logic e);
    beat_t b;
    b.d = d;
    b.e = e;
    src_q[k].push_back(b);
  endtask

  task automatic exp_add(input int k, input logic [7:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    x.s = 2'(k);
    exp_q.push_back(x);
  endtask

  function automatic logic busy();
    for (int k = 0; k < 4; k++) if (src_q[k].size() > 0) return 1'b1;
    return exp_q.size() > 0;
  endfunction

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      if (src_q[k].size() > 0 && !mask[k]) begin
        i_v[k]         = 1'b1;
        i_d[k*8 +: 8]  = src_q[k][0].d;
        i_e[k]         = src_q[k][0].e;
      end else begin
        i_v[k]         = 1'b0;
        i_d[k*8 +: 8]  = 8'h00;
        i_e[k]         = 1'b0;
      end
    end
  endtask

  // Drive at the falling edge, sample 1 ns later, then cross one rising edge.
  task automatic step();
    apply();
    #1;
    s_ir   = i_r;
    s_ov   = o_v;
    s_od   = o_d;
    s_fire = i_v & i_r;
    if (o_v && o_r) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got s=%0d d=%h, expected no beat", o_s, o_d);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("sb_beat", {21'd0, o_s, o_e, o_d}, {21'd0, x.s, x.e, x.d});
      end
    end
    for (int k = 0; k < 4; k++) if (s_fire[k]) void'(src_q[k].pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (busy() && cyc < 60) begin
      step();
      cyc++;
    end
    check({name, "_drained"}, {31'd0, busy()}, 32'd0);
  endtask

  initial begin
    int acc;
    n_checks = 0;
    n_fail   = 0;
    mask     = '0;
    i_v      = '0;
    i_e      = '0;
    i_d      = '0;
    o_r      = 1'b1;
    reset    = 1'b0;

    bp_tab[0] = '{o_r: 1'b0, ir: 4'b0001, ov: 1'b0, od: 8'h00};
    bp_tab[1] = '{o_r: 1'b0, ir: 4'b0001, ov: 1'b1, od: 8'h11};
    bp_tab[2] = '{o_r: 1'b0, ir: 4'b0000, ov: 1'b1, od: 8'h11};
    bp_tab[3] = '{o_r: 1'b0, ir: 4'b0000, ov: 1'b1, od: 8'h11};
    bp_tab[4] = '{o_r: 1'b1, ir: 4'b0000, ov: 1'b1, od: 8'h11};
    bp_tab[5] = '{o_r: 1'b1, ir: 4'b0001, ov: 1'b1, od: 8'h22};
    bp_tab[6] = '{o_r: 1'b1, ir: 4'b0000, ov: 1'b1, od: 8'h33};
    bp_tab[7] = '{o_r: 1'b1, ir: 4'b0000, ov: 1'b0, od: 8'h00};

    // Reset with all inputs valid, then round robin on single-beat packets.
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) begin
        src_add(k, 8'((k << 4) | j), 1'b1);
        exp_add(k, 8'((k << 4) | j), 1'b1);
      end
    apply();
    #1;
    check("rst_i_r", {28'd0, i_r}, 32'd0);
    check("rst_o_v", {31'd0, o_v}, 32'd0);
    check("rst_o_d_s", {22'd0, o_s, o_d}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rst_first_grant", {28'd0, s_ir}, 32'd1);
    step();
    check("rst_first_ov", {31'd0, s_ov}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      check("rr_rate", {31'd0, |s_fire}, 32'd1);
    end
    drain("rr");

    // Packet lock with a two-cycle gap from the owner.
    src_add(1, 8'h10, 1'b0);
    src_add(1, 8'h11, 1'b0);
    src_add(1, 8'h12, 1'b1);
    src_add(2, 8'h20, 1'b1);
    exp_add(1, 8'h10, 1'b0);
    exp_add(1, 8'h11, 1'b0);
    exp_add(1, 8'h12, 1'b1);
    exp_add(2, 8'h20, 1'b1);
    step();
    check("lock_first", {28'd0, s_fire}, 32'b0010);
    mask = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      step();
      check("lock_gap_i_r", {28'd0, s_ir}, 32'b0010);
    end
    mask = 4'b0000;
    drain("lock");

    // Backpressure: two accepted while stalled, then in-order release.
    src_add(0, 8'h11, 1'b1);
    src_add(0, 8'h22, 1'b1);
    src_add(0, 8'h33, 1'b1);
    exp_add(0, 8'h11, 1'b1);
    exp_add(0, 8'h22, 1'b1);
    exp_add(0, 8'h33, 1'b1);
    acc = 0;
    for (int v = 0; v < 8; v++) begin
      o_r = bp_tab[v].o_r;
      step();
      if (!bp_tab[v].o_r) acc += int'(s_fire[0]);
      check($sformatf("bp_i_r_%0d", v), {28'd0, s_ir}, {28'd0, bp_tab[v].ir});
      check($sformatf("bp_o_v_%0d", v), {31'd0, s_ov}, {31'd0, bp_tab[v].ov});
      if (bp_tab[v].ov) check($sformatf("bp_o_d_%0d", v), {24'd0, s_od}, {24'd0, bp_tab[v].od});
    end
    check("bp_accept_count", acc, 32'd2);
    o_r = 1'b1;
    drain("bp");

    // Pointer wrap: move ptr to 3, then 3/0/2 contend.
    src_add(2, 8'h2A, 1'b1);
    exp_add(2, 8'h2A, 1'b1);
    drain("wrap_prep");
    src_add(3, 8'h3B, 1'b1);
    src_add(0, 8'h0C, 1'b1);
    src_add(2, 8'h2D, 1'b1);
    exp_add(3, 8'h3B, 1'b1);
    exp_add(0, 8'h0C, 1'b1);
    exp_add(2, 8'h2D, 1'b1);
    step();
    check("wrap_first", {28'd0, s_ir}, 32'b1000);
    drain("wrap");

    // Reset in the middle of a packet with the buffer full.
    o_r = 1'b0;
    for (int j = 0; j < 4; j++) src_add(1, 8'h50 + 8'(j), 1'b0);
    for (int c = 0; c < 4; c++) step();
    check("mid_pre_o_v", {31'd0, s_ov}, 32'd1);
    check("mid_pre_i_r", {28'd0, s_ir}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_o_v", {31'd0, o_v}, 32'd0);
    check("mid_rst_i_r", {28'd0, i_r}, 32'd0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) src_q[k].delete();
    @(negedge clk);
    reset = 1'b1;
    o_r   = 1'b1;
    src_add(0, 8'hA0, 1'b1);
    src_add(2, 8'hA2, 1'b1);
    src_add(3, 8'hA3, 1'b1);
    exp_add(0, 8'hA0, 1'b1);
    exp_add(2, 8'hA2, 1'b1);
    exp_add(3, 8'hA3, 1'b1);
    step();
    check("mid_restart", {28'd0, s_ir}, 32'b0001);
    drain("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/base_aarb.md
Name: base_aarb

Overview:
- Round-robin, packet-aware arbiter that merges `ways` ready/valid input streams into one output stream.
- Sits directly upstream of a base_areg slice and drives its i_v/i_r/i_d.
- Holds a grant for the whole packet, from first beat through the beat with end-flag set.
- Output is registered through a 2-entry buffer, so no input ready depends combinationally on o_r.

Parameters:
- ways, 4, number of input streams (2..16).
- width, 8, data bits per beat.
- swidth, 2, bits of source id; 2**swidth >= ways is required.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- i_v  input  ways  per-input valid; bit k belongs to input k.
- i_r  output  ways  per-input ready.
- i_d  input  ways*width  per-input data; input k occupies bits [k*width : k*width+width-1].
- i_e  input  ways  per-input end-of-packet flag, qualified by i_v.
- o_r  input  1  downstream ready.
- o_v  output  1  output valid.
- o_d  output  width  output data.
- o_e  output  1  output end-of-packet flag.
- o_s  output  swidth  index of the input that produced this beat.

Behaviour:
- Transfer: input k transfers when i_v[k] & i_r[k]. Output transfers when o_v & o_r.
- Reset (reset==0):
  - count=0, ptr=0, locked=0, owner=0.
  - o_v=0, i_r=all 0 (forced low while reset is low), o_d/o_e/o_s=0.
  - Mid-operation reset discards buffered beats and any lock immediately.
- Buffer:
  - 2-entry FIFO holding {data, e, s}, with occupancy count 0..2.
  - o_v = (count!=0); head entry drives o_d/o_e/o_s.
  - Latency: input accept at edge N -> o_v high after edge N.
  - space = (count<2), taken from registered count only.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Full (count==2): no input accepted.
- Arbitration, combinational each cycle:
  - If locked: gnt = owner.
  - Else: gnt = first k with i_v[k]=1, searching ptr, ptr+1, ..., ways-1, 0, ..., ptr-1.
  - req = locked | (|i_v).
  - i_r[k] = space & req & (gnt==k); all other i_r bits are 0.
  - Only one i_r bit may be high in any cycle.
- Lock state machine (IDLE = locked 0, PKT = locked 1):
  - IDLE, accept with i_e[gnt]=0 -> PKT; owner=gnt.
  - IDLE, accept with i_e[gnt]=1 -> stay IDLE (single-beat packet); ptr=gnt+1 mod ways.
  - PKT, accept with i_e[owner]=1 -> IDLE; ptr=owner+1 mod ways.
  - PKT, no accept -> stay PKT, even if the owner deasserts i_v. Other inputs stay blocked.
- ptr wrap: owner ways-1 -> ptr=0.
- Stability: when o_v=1 and o_r=0, o_d/o_e/o_s hold.
- Throughput: with o_r tied high, one beat per cycle is sustained indefinitely.

Decomposition:
- Package base_aarb_pkg holds:
  - function for round-robin next-index with wrap.
  - localparam for buffer depth, 2.
- One natural sub-module: base_askid2(width) — the 2-entry ready/valid buffer.
  - Carries {data,e,s} as a single width+1+swidth bus.
  - Exposes i_v/i_r/i_d/o_v/o_r/o_d.
  - i_r registered.

Test Plan:
- Reset: hold reset=0 with i_v=4'b1111 -> i_r=0, o_v=0. Release; first edge accepts input 0 -> o_s=0, o_v=1 next cycle.
- Round robin: all four inputs always valid, single-beat packets (i_e=1), o_r=1 -> o_s sequence 0,1,2,3,0,1 at one beat/cycle.
- Packet lock:
  - Input 1 sends 3 beats (i_e=0,0,1) while input 2 is valid throughout -> three beats with o_s=1 before any o_s=2.
  - Input 1 drops i_v for 2 cycles mid-packet -> i_r[2] stays 0 during the gap.
- Backpressure:
  - o_r=0 with input 0 streaming d=0x11,0x22,0x33 -> exactly 2 accepted, i_r[0]=0 afterwards, o_d holds 0x11.
  - o_r=1 -> output 0x11,0x22,0x33 in order, no loss or duplication.
- Wrap: ptr=3 and input 3 sends a single-beat packet; inputs 0 and 2 both valid -> next grant is input 0, then 2.
- Reset mid-packet: assert reset during PKT with count=2 -> o_v=0 asynchronously. After release, arbitration restarts at input 0 with locked=0.
